// File: rtl/bayer_line_ctrl.sv
// bayer_line_ctrl: line-buffer addressing, Bayer phase and sync alignment for the demosaic datapath
//   sclk, s_rst          pixel clock, asynchronous active-high reset
//   i_vga_vsync/hsync/de raw timing from the VGA source
//   cfg_bayer            Bayer origin (00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR), latched at frame start
//   ram_wr_*/ram_rd_*    single-line dual-port buffer control (read-before-write, 1-cycle read)
//   o_phase/o_line_valid pixel phase and previous-line validity, aligned with RAM dout
//   o_vga_*              syncs delayed one cycle to match RAM dout
//   o_row_cnt/o_line_width/o_err_width/o_err_ovf  line bookkeeping and sticky per-frame errors
module bayer_line_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WIDTH = 1920
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              i_vga_vsync,
    input  logic              i_vga_hsync,
    input  logic              i_vga_de,
    input  logic [1:0]        cfg_bayer,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [1:0]        o_phase,
    output logic              o_line_valid,
    output logic              o_vga_vsync,
    output logic              o_vga_hsync,
    output logic              o_vga_de,
    output logic [15:0]       o_row_cnt,
    output logic [ADDR_W:0]   o_line_width,
    output logic              o_err_width,
    output logic              o_err_ovf
);
    localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, FRAME, LINE, BLANK} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   col_cnt, prev_width;
    logic [1:0]        cfg_latched;
    logic              pix, line_end;

    always_ff @(posedge sclk or posedge s_rst)
        if (s_rst) state <= IDLE;
        else       state <= state_nxt;

    // o_vga_de doubles as the previous-cycle de for edge detection; a pixel
    // only counts once a vsync has armed the frame and the line began with a
    // de rise (de still high when vsync drops is a line we never saw start).
    always_comb begin
        state_nxt = state;
        pix       = 1'b0;
        line_end  = 1'b0;
        if (i_vga_vsync) begin
            state_nxt = FRAME;
        end else if (state == LINE) begin
            pix       = i_vga_de;
            line_end  = !i_vga_de;
            state_nxt = i_vga_de ? LINE : BLANK;
        end else if (state != IDLE) begin
            pix       = i_vga_de && !o_vga_de;
            state_nxt = pix ? LINE : state;
        end
        ram_wr_en   = pix && col_cnt < MAXW;
        ram_rd_en   = pix && o_row_cnt != '0 && col_cnt < prev_width;
        ram_wr_addr = col_cnt[ADDR_W-1:0];
        ram_rd_addr = col_cnt[ADDR_W-1:0];
    end

    always_ff @(posedge sclk or posedge s_rst)
        if (s_rst) begin
            col_cnt      <= '0;
            prev_width   <= '0;
            cfg_latched  <= '0;
            o_row_cnt    <= '0;
            o_line_width <= '0;
            o_err_width  <= 1'b0;
            o_err_ovf    <= 1'b0;
            o_phase      <= '0;
            o_line_valid <= 1'b0;
            o_vga_vsync  <= 1'b0;
            o_vga_hsync  <= 1'b0;
            o_vga_de     <= 1'b0;
        end else begin
            o_vga_vsync  <= i_vga_vsync;
            o_vga_hsync  <= i_vga_hsync;
            o_vga_de     <= i_vga_de;
            o_line_valid <= ram_rd_en;
            if (pix)
                o_phase <= {o_row_cnt[0], col_cnt[0]} ^ cfg_latched;
            if (i_vga_vsync) begin
                col_cnt     <= '0;
                prev_width  <= '0;
                o_row_cnt   <= '0;
                o_err_width <= 1'b0;
                o_err_ovf   <= 1'b0;
                cfg_latched <= cfg_bayer;
            end else begin
                if (pix)
                    col_cnt <= col_cnt + (ADDR_W+1)'(col_cnt != MAXW);
                else if (!i_vga_de)
                    col_cnt <= '0;
                if (pix && col_cnt == MAXW)
                    o_err_ovf <= 1'b1;
                if (line_end) begin
                    o_row_cnt    <= o_row_cnt + 16'(o_row_cnt != 16'hFFFF);
                    prev_width   <= col_cnt;
                    o_line_width <= col_cnt;
                    if (o_row_cnt != '0 && col_cnt != prev_width)
                        o_err_width <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_bayer_line_ctrl.sv
// tb_bayer_line_ctrl: randomized directed bench for bayer_line_ctrl against a per-pixel line model
module tb_bayer_line_ctrl;
    localparam int AW   = 3;
    localparam int MAXW = 8;

    logic          sclk = 0, s_rst = 1;
    logic          i_vga_vsync = 0, i_vga_hsync = 0, i_vga_de = 0;
    logic [1:0]    cfg_bayer = 0;
    logic          ram_wr_en, ram_rd_en, o_line_valid;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [1:0]    o_phase;
    logic          o_vga_vsync, o_vga_hsync, o_vga_de, o_err_width, o_err_ovf;
    logic [15:0]   o_row_cnt;
    logic [AW:0]   o_line_width;

    bayer_line_ctrl #(.ADDR_W(AW), .MAX_WIDTH(MAXW)) dut (
        .sclk(sclk), .s_rst(s_rst), .i_vga_vsync(i_vga_vsync), .i_vga_hsync(i_vga_hsync),
        .i_vga_de(i_vga_de), .cfg_bayer(cfg_bayer), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .o_phase(o_phase), .o_line_valid(o_line_valid),
        .o_vga_vsync(o_vga_vsync), .o_vga_hsync(o_vga_hsync), .o_vga_de(o_vga_de),
        .o_row_cnt(o_row_cnt), .o_line_width(o_line_width), .o_err_width(o_err_width), .o_err_ovf(o_err_ovf)
    );

    always #5 sclk = ~sclk;

    int checks = 0, passed = 0;

    // reference model: frame armed by vsync, pixel index within the line, line history
    bit       armed, in_line, de_prev, errw, errov;
    int       k, row, prev, lw;
    logic [1:0] cfg, ephase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        armed = 0; in_line = 0; de_prev = 0; errw = 0; errov = 0;
        k = 0; row = 0; prev = 0; lw = 0; cfg = 0; ephase = 0;
    endtask

    task automatic cyc(input bit vs, input bit de);
        bit hs, ewr, erd;
        int cw, eaddr;
        @(negedge sclk);
        hs = 1'($urandom);
        i_vga_vsync = vs; i_vga_hsync = hs; i_vga_de = de;
        ewr = 0; erd = 0; eaddr = 0;
        if (vs) begin
            armed = 1; in_line = 0; k = 0; row = 0; prev = 0; errw = 0; errov = 0; cfg = cfg_bayer;
        end else if (de) begin
            if (armed && (in_line || !de_prev)) begin
                cw = k < MAXW ? k : MAXW;
                ewr = k < MAXW;
                erd = row >= 1 && k < prev;
                eaddr = cw % (1 << AW);
                ephase = 2'((row % 2) * 2 + (cw % 2)) ^ cfg;
                if (k >= MAXW) errov = 1;
                in_line = 1;
                k++;
            end
        end else begin
            if (in_line) begin
                cw = k < MAXW ? k : MAXW;
                if (row >= 1 && cw != prev) errw = 1;
                if (row < 65535) row++;
                prev = cw; lw = cw; in_line = 0;
            end
            k = 0;
        end
        #1;
        chk("wr_en", 32'(ram_wr_en), 32'(ewr));
        chk("rd_en", 32'(ram_rd_en), 32'(erd));
        if (ewr || erd) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(eaddr));
            chk("rd_addr", 32'(ram_rd_addr), 32'(eaddr));
        end
        @(posedge sclk); #1;
        chk("line_valid", 32'(o_line_valid), 32'(erd));
        chk("phase", 32'(o_phase), 32'(ephase));
        chk("vga_sync", {29'd0, o_vga_vsync, o_vga_hsync, o_vga_de}, {29'd0, vs, hs, de});
        chk("row_cnt", 32'(o_row_cnt), 32'(row));
        chk("line_width", 32'(o_line_width), 32'(lw));
        chk("err_width", 32'(o_err_width), 32'(errw));
        chk("err_ovf", 32'(o_err_ovf), 32'(errov));
        de_prev = de;
    endtask

    task automatic line(input int w, input int gap);
        repeat (w) cyc(0, 1);
        repeat (gap) cyc(0, 0);
    endtask

    task automatic vsync(input logic [1:0] c, input int n);
        cfg_bayer = c;
        repeat (n) cyc(1, 0);
        repeat (2) cyc(0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"}, {30'd0, ram_wr_en, ram_rd_en}, 0);
        chk({tag, "_addr"}, {26'd0, ram_wr_addr, ram_rd_addr}, 0);
        chk({tag, "_out"}, {o_phase, o_line_valid, o_vga_vsync, o_vga_hsync, o_vga_de, o_err_width, o_err_ovf}, 0);
        chk({tag, "_cnt"}, {o_row_cnt, 12'd0, o_line_width}, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge sclk);
        check_all_zero("reset");
        s_rst = 0;
        line(5, 2);
        vsync(2'b00, 2);
        repeat (4) line(8, 3);
        vsync(2'b11, 3);
        repeat (4) line(8, 2);
        vsync(2'b01, 2);
        line(8, 2); line(8, 2); line(6, 2);
        vsync(2'b10, 2);
        line(10, 2); line(3, 2);
        vsync(2'b00, 2);
        line(8, 2); line(8, 2);
        repeat (3) cyc(0, 1);
        cyc(1, 1); cyc(1, 1); cyc(1, 0);
        repeat (2) cyc(0, 1);
        cyc(0, 0);
        line(8, 2); line(5, 2);
        for (int f = 0; f < 6; f++) begin
            vsync(2'($urandom), $urandom_range(1, 3));
            for (int l = 0; l < $urandom_range(2, 6); l++) begin
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(1, 5)) cyc(0, 1);
                    cyc(1, $urandom_range(0, 1) == 1);
                    cyc(1, 0);
                end
                line($urandom_range(1, 10), $urandom_range(1, 3));
            end
        end
        repeat (3) cyc(0, 1);
        @(negedge sclk);
        #2 s_rst = 1;
        #1 check_all_zero("midline_rst");
        model_reset();
        @(negedge sclk);
        s_rst = 0;
        i_vga_de = 0;
        line(6, 2);
        line(4, 2);
        vsync(2'b11, 2);
        line(7, 2); line(7, 2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/bayer_line_ctrl.md
Name: bayer_line_ctrl

Overview:
- Sequencing controller for the Bayer demosaic datapath.
- Replaces the free-running line FIFO control with explicit addressing of a single-line dual-port buffer RAM (read-before-write, 1-cycle read latency).
- Tracks frame, row and column position and derives the 2-bit Bayer phase for the RGB mux.
- Delays syncs to align with RAM read data, and flags malformed lines.
- Sits between the VGA timing source and the raw-to-RGB interpolation logic.

Parameters:
- ADDR_W, 11, line-buffer address width.
- MAX_WIDTH, 1920, maximum active pixels per line; must be ≤ 2^ADDR_W.

Ports:
- sclk  in  1  pixel clock.
- s_rst  in  1  reset, asynchronous, active-high.
- i_vga_vsync  in  1  vertical sync, active-high.
- i_vga_hsync  in  1  horizontal sync, passed through.
- i_vga_de  in  1  active-pixel enable.
- cfg_bayer  in  2  Bayer origin: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR. Sampled at frame start.
- ram_wr_en  out  1  line-buffer write enable.
- ram_wr_addr  out  ADDR_W  write address.
- ram_rd_en  out  1  line-buffer read enable.
- ram_rd_addr  out  ADDR_W  read address.
- o_phase  out  2  {row parity, col parity} XOR latched cfg_bayer, aligned with RAM dout.
- o_line_valid  out  1  previous-line data in RAM is valid; aligned with RAM dout.
- o_vga_vsync  out  1  vsync delayed 1 cycle.
- o_vga_hsync  out  1  hsync delayed 1 cycle.
- o_vga_de  out  1  de delayed 1 cycle.
- o_row_cnt  out  16  completed lines in current frame.
- o_line_width  out  ADDR_W+1  pixel count of last completed line.
- o_err_width  out  1  sticky per frame: line width differed from previous line.
- o_err_ovf  out  1  sticky per frame: line exceeded MAX_WIDTH.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; latched cfg 00.
- State machine:
  - IDLE → FRAME when i_vga_vsync = 1.
  - FRAME → LINE on i_vga_de rising edge while vsync = 0.
  - LINE → BLANK on de falling edge.
  - BLANK → LINE on de rising edge.
  - Any state → FRAME when i_vga_vsync = 1 (mid-line vsync aborts the line; a partial line is not counted).
- In FRAME (vsync high): col_cnt = 0, row_cnt = 0, prev_width = 0, both error flags cleared, cfg_bayer latched.
- col_cnt:
  - Increments on every de = 1 cycle; resets to 0 on the first cycle with de = 0.
  - Saturates at MAX_WIDTH.
- ram_wr_en = de && col_cnt < MAX_WIDTH; ram_wr_addr = col_cnt[ADDR_W-1:0]. Combinational from registered col_cnt, same cycle as de.
- ram_rd_en = de && row_cnt ≥ 1 && col_cnt < prev_width; ram_rd_addr = ram_wr_addr.
  - Same-address read/write: RAM returns old data (the previous line).
- On the LINE → BLANK transition (de falling edge):
  - row_cnt += 1, saturating at 16'hFFFF.
  - prev_width = col_cnt; o_line_width = col_cnt.
  - o_err_width is set if row_cnt ≥ 1 and col_cnt ≠ prev_width.
- o_err_ovf is set when de = 1 while col_cnt = MAX_WIDTH; further writes are suppressed for that line.
- o_phase and o_line_valid are registered (1-cycle latency, matching RAM dout and o_vga_de):
  - o_phase = {row_cnt[0], col_cnt[0]} ^ cfg_latched.
  - o_line_valid = ram_rd_en delayed 1 cycle.
  - When de = 0, o_phase holds its value and o_line_valid = 0.
- Sync delays: o_vga_* are de/hsync/vsync registered once. They are reset by s_rst only; the state machine does not touch them.
- Simultaneous vsync and de: vsync wins. No write, no read, counters cleared.
- Asynchronous reset mid-line: everything returns to reset values immediately. The next frame requires a vsync before any RAM access.

Test Plan:
- Frame of 4 lines × 8 pixels, cfg_bayer = 00 → ram_wr_en is high for 8 cycles per line with addresses 0..7.
  - Line 0: ram_rd_en stays 0.
  - Lines 1–3: ram_rd_en high with rd_addr = wr_addr.
  - o_row_cnt ends at 4; o_line_width = 8.
- Same frame with cfg_bayer = 11 → o_phase sequence on line 0 is 11, 10, 11, 10…; on line 1 it is 01, 00, 01, 00…; each value appears one cycle after the matching de.
- Line widths 8, 8, 6 → o_err_width rises after the third line's de fall; on the third line ram_rd_en covers all 6 pixels.
  - Next vsync clears o_err_width.
- MAX_WIDTH = 8, one line of 10 pixels → ram_wr_en for 8 cycles only; o_err_ovf = 1; o_line_width = 8.
- Vsync asserted at pixel 3 of line 2 → no RAM enables during vsync; row_cnt = 0.
  - The next line after vsync has no reads (row 0).
- s_rst pulsed mid-line → all outputs 0 in the same cycle. De without a preceding vsync produces no RAM enables.
